// File: rtl/display_scheduler.sv
// Page sequencer for the two-field clock display: rotates MS <-> HM on a tick dwell,
// with debounced next/hold buttons. Optional blank gap via DISPLAY_SCHED_BLANK_GAP_EN.
module display_scheduler #(
  parameter int DWELL_S      = 15,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       btn_next,
  input  logic       btn_hold,
  input  logic [5:0] segundo,
  input  logic [5:0] minuto,
  input  logic [5:0] horas,
  output logic [5:0] out1,
  output logic [5:0] out2,
  output logic [1:0] page,
  output logic       hold,
  output logic [4:0] dwell_left
);

  typedef enum logic [1:0] {
    ST_MS    = 2'd0,
    ST_HM    = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  localparam logic [4:0] RELOAD  = 5'(DWELL_S);
  localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_CYC - 1);

  // Index 0 is the next button, index 1 is the hold button.
  logic [1:0] raw;
  logic [1:0] sync1_q, sync2_q;
  logic [1:0] acc_q, acc_d;
  logic [3:0] cnt_q [2];
  logic [3:0] cnt_d [2];
  logic [1:0] pulse_q;

  assign raw = {btn_hold, btn_next};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      acc_d[i] = acc_q[i];
      cnt_d[i] = 4'd0;
      if (sync2_q[i] != acc_q[i]) begin
        if (cnt_q[i] == DB_LAST) acc_d[i] = sync2_q[i];
        else                     cnt_d[i] = cnt_q[i] + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
      acc_q   <= 2'b00;
      pulse_q <= 2'b00;
      for (int i = 0; i < 2; i++) cnt_q[i] <= 4'd0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      acc_q   <= acc_d;
      pulse_q <= acc_d & ~acc_q;
      for (int i = 0; i < 2; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  logic next_p, hold_p, tick_cnt;
  state_t state_q, other_page;
  logic       hold_q;
  logic [4:0] dwell_q;
  logic [5:0] out1_q, out2_q;
`ifdef DISPLAY_SCHED_BLANK_GAP_EN
  state_t target_q;
`endif

  assign next_p     = pulse_q[0];
  assign hold_p     = pulse_q[1];
  assign tick_cnt   = tick_1hz & ~hold_q;
  assign other_page = (state_q == ST_MS) ? ST_HM : ST_MS;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_MS;
      hold_q  <= 1'b0;
      dwell_q <= RELOAD;
      out1_q  <= 6'd0;
      out2_q  <= 6'd0;
`ifdef DISPLAY_SCHED_BLANK_GAP_EN
      target_q <= ST_MS;
`endif
    end else begin
      if (hold_p) hold_q <= ~hold_q;

      case (state_q)
        ST_MS:   begin out1_q <= minuto; out2_q <= segundo; end
        ST_HM:   begin out1_q <= horas;  out2_q <= minuto;  end
        default: begin out1_q <= 6'h3F;  out2_q <= 6'h3F;   end
      endcase

      case (state_q)
        ST_MS, ST_HM: begin
          // A button pulse and an expiring tick in the same cycle merge into one advance.
          if (next_p || (tick_cnt && dwell_q == 5'd1)) begin
            dwell_q <= RELOAD;
`ifdef DISPLAY_SCHED_BLANK_GAP_EN
            state_q  <= ST_BLANK;
            target_q <= other_page;
`else
            state_q  <= other_page;
`endif
          end else if (tick_cnt) begin
            dwell_q <= dwell_q - 5'd1;
          end
        end
`ifdef DISPLAY_SCHED_BLANK_GAP_EN
        // Hold is ignored here so a frozen display never sticks on blank.
        ST_BLANK: if (next_p || tick_1hz) state_q <= target_q;
`endif
        default: state_q <= ST_MS;
      endcase
    end
  end

  assign out1       = out1_q;
  assign out2       = out2_q;
  assign page       = state_q;
  assign hold       = hold_q;
  assign dwell_left = dwell_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler (DWELL_S=3, DEBOUNCE_CYC=4); expected snapshots
// are queued by the driver and compared by an independent negedge monitor.
module tb_display_scheduler;

  logic       clk;
  logic       reset;
  logic       tick_1hz;
  logic       btn_next;
  logic       btn_hold;
  logic [5:0] segundo, minuto, horas;
  logic [5:0] out1, out2;
  logic [1:0] page;
  logic       hold;
  logic [4:0] dwell_left;

  display_scheduler #(.DWELL_S(3), .DEBOUNCE_CYC(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick_1hz   (tick_1hz),
    .btn_next   (btn_next),
    .btn_hold   (btn_hold),
    .segundo    (segundo),
    .minuto     (minuto),
    .horas      (horas),
    .out1       (out1),
    .out2       (out2),
    .page       (page),
    .hold       (hold),
    .dwell_left (dwell_left)
  );

  // Clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required summary before 200000");
    $fatal(1);
  end

  // Scoreboard: snapshot = {page, hold, dwell_left, out1, out2}
  logic [19:0] exp_q[$];
  string       name_q[$];
  logic        chk_req = 1'b0;
  int          n_vec = 0;
  int          n_err = 0;

  function automatic logic [19:0] ev(int pg, int hd, int dw, int o1, int o2);
    return {2'(pg), 1'(hd), 5'(dw), 6'(o1), 6'(o2)};
  endfunction

  always @(negedge clk) begin
    logic [19:0] act, e;
    string nm;
    if (chk_req) begin
      act = {page, hold, dwell_left, out1, out2};
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL empty_queue: got %h, required a queued expectation", act);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (act !== e) begin
          n_err++;
          $display("FAIL %s: got page=%0d hold=%0d dwell=%0d out=%0d/%0d, required page=%0d hold=%0d dwell=%0d out=%0d/%0d",
                   nm, act[19:18], act[17], act[16:12], act[11:6], act[5:0],
                   e[19:18], e[17], e[16:12], e[11:6], e[5:0]);
        end
      end
    end
  end

  // Driver tasks: every step leaves time at posedge+1
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input logic [19:0] e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
    chk_req = 1'b1;
    @(negedge clk);
    #1 chk_req = 1'b0;
  endtask

  task automatic tick_once();
    tick_1hz = 1'b1;
    step(1);
    tick_1hz = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick_once();
      step(1);
    end
  endtask

  task automatic press(input int which);
    if (which == 0) btn_next = 1'b1; else btn_hold = 1'b1;
    step(10);
    btn_next = 1'b0;
    btn_hold = 1'b0;
    step(8);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    step(1);
  endtask

  initial begin
    reset    = 1'b0;
    tick_1hz = 1'b0;
    btn_next = 1'b0;
    btn_hold = 1'b0;
    segundo  = 6'd42;
    minuto   = 6'd17;
    horas    = 6'd9;
    step(3);
    chk(ev(0, 0, 3, 0, 0), "reset_values");
    reset = 1'b1;
    step(1);
    chk(ev(0, 0, 3, 17, 42), "ms_fields");

`ifdef DISPLAY_SCHED_BLANK_GAP_EN
    ticks(2);
    tick_once();
    chk(ev(2, 0, 3, 17, 42), "blank_enter");
    step(1);
    chk(ev(2, 0, 3, 63, 63), "blank_out");
    tick_once();
    chk(ev(1, 0, 3, 63, 63), "blank_exit_tick");
    step(1);
    chk(ev(1, 0, 3, 9, 17), "hm_out");
    ticks(2);
    chk(ev(1, 0, 1, 9, 17), "hm_dwell_uncounted_exit");
    tick_once();
    chk(ev(2, 0, 3, 9, 17), "blank_again");
    btn_next = 1'b1;
    step(7);
    chk(ev(0, 0, 3, 63, 63), "next_exits_blank");
    step(3);
    btn_next = 1'b0;
    step(8);
    chk(ev(0, 0, 3, 17, 42), "next_no_skip");
    ticks(3);
    chk(ev(2, 0, 3, 63, 63), "blank_third");
    reset = 1'b0;
    chk(ev(0, 0, 3, 0, 0), "reset_in_blank");
    reset = 1'b1;
    step(1);
`else
    // Auto-advance on the third tick
    ticks(2);
    chk(ev(0, 0, 1, 17, 42), "dwell_count");
    tick_once();
    chk(ev(1, 0, 3, 17, 42), "auto_adv_page");
    step(1);
    chk(ev(1, 0, 3, 9, 17), "auto_adv_out");

    // Debounced next: page flips on the 7th edge after the raw edge
    do_reset();
    btn_next = 1'b1;
    step(6);
    chk(ev(0, 0, 3, 17, 42), "next_before_lat");
    step(1);
    chk(ev(1, 0, 3, 17, 42), "next_lat7");
    step(3);
    btn_next = 1'b0;
    step(8);
    chk(ev(1, 0, 3, 9, 17), "next_single");

    // Bounce 1-0-1 at 2 clk each
    btn_next = 1'b1; step(2);
    btn_next = 1'b0; step(2);
    btn_next = 1'b1; step(2);
    btn_next = 1'b0; step(10);
    chk(ev(1, 0, 3, 9, 17), "bounce_ignored");

    // Short release while held gives no second pulse
    btn_next = 1'b1; step(8);
    btn_next = 1'b0; step(2);
    btn_next = 1'b1; step(8);
    btn_next = 1'b0; step(8);
    chk(ev(0, 0, 3, 17, 42), "short_release");

    // Hold freezes rotation, next still honoured
    ticks(1);
    chk(ev(0, 0, 2, 17, 42), "pre_hold");
    press(1);
    chk(ev(0, 1, 2, 17, 42), "hold_on");
    ticks(10);
    chk(ev(0, 1, 2, 17, 42), "hold_ticks_frozen");
    press(0);
    chk(ev(1, 1, 3, 9, 17), "next_in_hold");
    press(1);
    chk(ev(1, 0, 3, 9, 17), "hold_off");
    ticks(2);
    chk(ev(1, 0, 1, 9, 17), "resume_count");
    ticks(1);
    chk(ev(0, 0, 3, 17, 42), "resume_adv");

    // next pulse coincident with the expiring tick
    do_reset();
    ticks(2);
    btn_next = 1'b1;
    step(6);
    tick_once();
    chk(ev(1, 0, 3, 17, 42), "coincident_adv");
    step(3);
    btn_next = 1'b0;
    step(8);
    chk(ev(1, 0, 3, 9, 17), "coincident_once");

    // Out-of-range fields pass through
    minuto = 6'd63;
    horas  = 6'd31;
    step(1);
    chk(ev(1, 0, 3, 31, 63), "passthrough");
    minuto = 6'd17;
    horas  = 6'd9;

    // Reset mid-dwell, then first tick counts as tick 1 of MS
    ticks(1);
    reset = 1'b0;
    chk(ev(0, 0, 3, 0, 0), "reset_mid_dwell");
    reset = 1'b1;
    step(1);
    tick_once();
    chk(ev(0, 0, 2, 17, 42), "first_tick_after_reset");
`endif

    step(2);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/display_scheduler.md
# display_scheduler

Sequencing controller for the clock's two-field display path. It rotates the displayed pair between minute:second and hour:minute on a programmable dwell. A debounced "next" button forces an immediate page change, and a "hold" button freezes rotation. It sits between the timekeeping counters (segundo/minuto/horas) and the display encoders, and replaces the free-running page toggle with a single registered, reset-safe sequencer.

## Interface
Parameters:
- DWELL_S, 15: number of tick_1hz pulses a page is shown before auto-advance (1..31).
- DEBOUNCE_CYC, 4: consecutive clk cycles a synchronized button level must be stable to be accepted (1..15).

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- tick_1hz  input  1  one-clk-wide enable pulse, once per second.
- btn_next  input  1  raw button, active-high, asynchronous to clk.
- btn_hold  input  1  raw button, active-high, asynchronous to clk.
- segundo  input  6  seconds value 0..59.
- minuto  input  6  minutes value 0..59.
- horas  input  6  hours value 0..23.
- out1  output  6  left display field (registered).
- out2  output  6  right display field (registered).
- page  output  2  current state: 0 = MS, 1 = HM, 2 = BLANK.
- hold  output  1  rotation frozen flag.
- dwell_left  output  5  ticks remaining on the current page.

## Operation
- Button path, per button:
  - 2-FF synchronizer.
  - Stability counter: the accepted level updates only after DEBOUNCE_CYC consecutive equal samples.
  - A rising edge of the accepted level yields a one-clk pulse: next_p or hold_p.
- hold_p toggles hold.
- FSM states and outputs:
  - MS: out1 = minuto, out2 = segundo.
  - HM: out1 = horas, out2 = minuto.
  - BLANK: exists only with the configuration macro; outputs 6'h3F on both fields.
- Dwell counter:
  - dwell_left decrements by 1 on tick_1hz when hold = 0 and state is MS or HM.
  - A tick with dwell_left == 1 is an auto-advance event.
- Advance event (auto or next_p):
  - MS goes to HM, HM goes to MS.
  - dwell_left reloads to DWELL_S in the same cycle.
- next_p is honoured while hold = 1. hold stays 1 and the counter is reloaded, not decremented.
- Simultaneous auto-advance and next_p in one cycle advances exactly one page.
- tick_1hz while hold = 1 has no effect on dwell_left or page.
- Out-of-range field inputs pass through unmodified. No clamping.
- Width rule: dwell_left is 5 bits. Reload is DWELL_S[4:0]; it never underflows because the counter reloads at 1.

## Timing
- Reset values, all asynchronous on reset low:
  - page = 0 (MS), hold = 0, dwell_left = DWELL_S, out1 = 0, out2 = 0.
  - Synchronizers and debounce counters are 0; accepted levels are 0.
- out1/out2 latency: 1 clk from a change in page or the field inputs.
- Button latency: raw edge to next_p/hold_p is 2 clk (synchronizer) + DEBOUNCE_CYC clk. page updates 1 clk after the pulse.
- Auto-advance: page changes on the clk edge that samples the DWELL_S-th accepted tick.
- Button held high produces exactly one pulse. A release shorter than DEBOUNCE_CYC produces no new pulse.
- Reset asserted mid-dwell, mid-debounce or in BLANK returns to the reset values immediately. After release, the first tick counts as tick 1 of MS.

## Configuration
- DISPLAY_SCHED_BLANK_GAP_EN defined:
  - Every advance event first enters BLANK. dwell_left holds the reloaded DWELL_S.
  - BLANK exits to the target page on the next tick_1hz. That tick is not counted against the new dwell.
  - next_p during BLANK exits immediately to the target page; it does not skip a further page.
  - hold does not extend BLANK.
- DISPLAY_SCHED_BLANK_GAP_EN undefined:
  - BLANK is unreachable and page never reads 2.
  - Advance events switch the page directly.

## Test plan
- Reset then 3 ticks, with DWELL_S = 3, segundo = 42, minuto = 17, horas = 9: out = 17/42 until the 3rd tick; 1 clk after the 3rd tick out = 9/17, dwell_left = 3.
- btn_next high for 10 clk, DEBOUNCE_CYC = 4: exactly one advance, page 0 to 1, at clk 7 after the raw edge; dwell_left = 3.
- btn_next bounces 1-0-1 with each level held 2 clk, then stays low: no page change.
- Hold: press hold, apply 10 ticks: page and dwell_left unchanged, hold = 1. Press next: page toggles, dwell_left = 3, hold still 1. Press hold again: rotation resumes.
- next_p coincident with the 3rd tick: page changes once, 0 to 1, and dwell_left = 3.
- With DISPLAY_SCHED_BLANK_GAP_EN, DWELL_S = 3:
  - The 3rd tick gives page = 2 and out = 3F/3F.
  - The next tick gives page = 1, then 3 more ticks are needed before the next blank.
  - Reset asserted while in BLANK gives page = 0 and out = 0/0.
